// File: rtl/branch_exec_unit_pkg.sv
// Shared definitions for the branch execution unit: RV32 control-flow
// opcodes, branch funct3 codes, FSM states and the predictor counter helpers.
package branch_exec_unit_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    // Weakly not-taken: the counter value every entry starts from.
    localparam logic [1:0] CTR_RESET = 2'b01;

    typedef enum logic {
        ST_IDLE,
        ST_EVAL
    } state_t;

    // Saturating 2-bit counter step toward taken (max 3) or not-taken (min 0).
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != 2'b11) nxt = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters with one combinational
// read port (fetch lookup) and one update port (branch resolution).
// A read that collides with an update sees the value before the update.
module bht_2bit
    import branch_exec_unit_pkg::*;
#(
    parameter int ENTRIES = 16,
    localparam int IDX_W = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] ctr [ENTRIES];

    assign rd_taken = ctr[rd_idx][1];

    // Counter array: reset every entry to weakly not-taken, else step the updated entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= CTR_RESET;
            end
        end else if (upd_en) begin
            ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/branch_exec_unit.sv
// Branch execution unit: accepts one control-flow instruction at a time,
// waits for its operands to clear the scoreboard, resolves direction and
// target, reports a one-cycle result and trains the 2-bit predictor.
module branch_exec_unit
    import branch_exec_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int DEP_W       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  imm_ex,
    input  logic [XLEN-1:0]  pc_addr,
    input  logic             pred_taken_in,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [DEP_W-1:0] data1_depend,
    input  logic [DEP_W-1:0] data2_depend,
    input  logic [XLEN-1:0]  query_pc,
    output logic             query_taken,
    output logic             j_valid,
    output logic             j_accept,
    output logic             mispredict,
    output logic             misalign,
    output logic [XLEN-1:0]  redirect_addr,
    output logic [XLEN-1:0]  link_data,
    output logic             link_we,
    output logic             j_wait
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    state_t state_q, state_d;

    logic [6:0]      opcode_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] pc_q;
    logic            pred_q;

    logic            transfer;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] br_sum;
    logic [XLEN-1:0] jalr_sum;

    logic            is_jal, is_jalr, is_br, cond;
    logic            op_ready, taken;
    logic [XLEN-1:0] target;
    logic            res_misalign, res_mispredict;
    logic [XLEN-1:0] res_redirect;
    logic            resolve;
    logic            bht_upd_en;

    logic            unused_query_bits;

    assign in_ready = (state_q == ST_IDLE) && !flush;
    assign transfer = in_valid && in_ready;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign br_sum   = pc_q + imm_q;
    assign jalr_sum = rs1_data + imm_q;

    assign resolve    = (state_q == ST_EVAL) && op_ready && !flush;
    assign bht_upd_en = resolve && is_br;

    assign unused_query_bits = ^{query_pc[XLEN-1:IDX_W+2], query_pc[1:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: accept in IDLE, leave EVAL once operands are ready; flush always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (transfer) state_d = ST_EVAL;
            ST_EVAL: if (op_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // Capture the issued instruction fields; only opcode and funct3 of instr matter here.
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q <= '0;
            funct3_q <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            pred_q   <= 1'b0;
        end else if (transfer) begin
            opcode_q <= instr[6:0];
            funct3_q <= instr[14:12];
            imm_q    <= imm_ex;
            pc_q     <= pc_addr;
            pred_q   <= pred_taken_in;
        end
    end

    // Decode, operand readiness, direction, target and resolution flags from live operands.
    always_comb begin
        is_jal  = (opcode_q == OPC_JAL);
        is_jalr = (opcode_q == OPC_JALR);
        is_br   = 1'b0;
        cond    = 1'b0;
        if (opcode_q == OPC_BRANCH) begin
            case (funct3_q)
                F3_BEQ:  begin is_br = 1'b1; cond = (rs1_data == rs2_data); end
                F3_BNE:  begin is_br = 1'b1; cond = (rs1_data != rs2_data); end
                F3_BLT:  begin is_br = 1'b1; cond = ($signed(rs1_data) <  $signed(rs2_data)); end
                F3_BGE:  begin is_br = 1'b1; cond = ($signed(rs1_data) >= $signed(rs2_data)); end
                F3_BLTU: begin is_br = 1'b1; cond = (rs1_data <  rs2_data); end
                F3_BGEU: begin is_br = 1'b1; cond = (rs1_data >= rs2_data); end
                default: begin is_br = 1'b0; cond = 1'b0; end
            endcase
        end

        op_ready = 1'b1;
        if (is_jalr) begin
            op_ready = (data1_depend == '0);
        end else if (is_br) begin
            op_ready = (data1_depend == '0) && (data2_depend == '0);
        end

        taken  = is_jal || is_jalr || (is_br && cond);
        target = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : br_sum;

        res_misalign   = taken && target[1];
        res_mispredict = 1'b0;
        if (!res_misalign) begin
            if (is_jalr) begin
                res_mispredict = 1'b1;
            end else if (is_jal || is_br) begin
                res_mispredict = (taken != pred_q);
            end
        end

        res_redirect = taken ? target : pc_plus4;
    end

    // Result registers: pulse strobes for one cycle, hold the rest until the next result.
    always_ff @(posedge clk) begin
        if (rst) begin
            j_valid       <= 1'b0;
            j_accept      <= 1'b0;
            mispredict    <= 1'b0;
            misalign      <= 1'b0;
            link_we       <= 1'b0;
            j_wait        <= 1'b0;
            redirect_addr <= '0;
            link_data     <= '0;
        end else begin
            j_valid <= 1'b0;
            link_we <= 1'b0;
            j_wait  <= 1'b0;
            if (!flush && state_q == ST_EVAL) begin
                if (op_ready) begin
                    j_valid       <= 1'b1;
                    j_accept      <= taken;
                    mispredict    <= res_mispredict;
                    misalign      <= res_misalign;
                    link_we       <= is_jal || is_jalr;
                    redirect_addr <= res_redirect;
                    link_data     <= pc_plus4;
                end else begin
                    j_wait <= 1'b1;
                end
            end
        end
    end

    bht_2bit #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (query_pc[IDX_W+1:2]),
        .rd_taken  (query_taken),
        .upd_en    (bht_upd_en),
        .upd_idx   (pc_q[IDX_W+1:2]),
        .upd_taken (cond)
    );

endmodule

// File: tb/tb_branch_exec_unit.sv
// Directed self-checking bench for branch_exec_unit with a result scoreboard
// and a reference model of the branch history table.
module tb_branch_exec_unit;

    localparam int XLEN = 32;
    localparam int ENT  = 16;
    localparam int DEPW = 2;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm_ex;
    logic [XLEN-1:0] pc_addr;
    logic            pred_taken_in;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [DEPW-1:0] data1_depend;
    logic [DEPW-1:0] data2_depend;
    logic [XLEN-1:0] query_pc;
    logic            query_taken;
    logic            j_valid;
    logic            j_accept;
    logic            mispredict;
    logic            misalign;
    logic [XLEN-1:0] redirect_addr;
    logic [XLEN-1:0] link_data;
    logic            link_we;
    logic            j_wait;

    branch_exec_unit #(
        .XLEN        (XLEN),
        .BHT_ENTRIES (ENT),
        .DEP_W       (DEPW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .imm_ex        (imm_ex),
        .pc_addr       (pc_addr),
        .pred_taken_in (pred_taken_in),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .data1_depend  (data1_depend),
        .data2_depend  (data2_depend),
        .query_pc      (query_pc),
        .query_taken   (query_taken),
        .j_valid       (j_valid),
        .j_accept      (j_accept),
        .mispredict    (mispredict),
        .misalign      (misalign),
        .redirect_addr (redirect_addr),
        .link_data     (link_data),
        .link_we       (link_we),
        .j_wait        (j_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        accept;
        logic        mispred;
        logic        misalign;
        logic        link_we;
        logic [31:0] redirect;
        logic [31:0] link;
        logic        upd;
        logic        tk;
        logic [3:0]  idx;
    } exp_t;

    exp_t       sb[$];
    exp_t       last_e;
    logic [1:0] bht_m [ENT];
    int         total = 0;
    int         bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
        return {17'h00000, f3, 5'd1, opc};
    endfunction

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    // Reference model of one resolution given the issued fields and operand values.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] imm, input logic pred,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        valid, tk, jr;
        logic [31:0] tgt;
        opc = ins[6:0];
        f3  = ins[14:12];
        valid = 1'b0; tk = 1'b0; jr = 1'b0;
        tgt = pc + imm;
        e.accept = 1'b0; e.mispred = 1'b0; e.misalign = 1'b0; e.link_we = 1'b0;
        e.redirect = pc + 32'd4; e.link = pc + 32'd4;
        e.upd = 1'b0; e.tk = 1'b0; e.idx = pc[5:2];
        if (opc == 7'h6f) begin
            valid = 1'b1; tk = 1'b1; e.link_we = 1'b1;
        end else if (opc == 7'h67) begin
            valid = 1'b1; tk = 1'b1; jr = 1'b1; e.link_we = 1'b1;
            tgt = (a + imm) & 32'hFFFF_FFFE;
        end else if (opc == 7'h63) begin
            valid = 1'b1;
            case (f3)
                3'd0: tk = (a == b);
                3'd1: tk = (a != b);
                3'd4: tk = ($signed(a) < $signed(b));
                3'd5: tk = ($signed(a) >= $signed(b));
                3'd6: tk = (a < b);
                3'd7: tk = (a >= b);
                default: valid = 1'b0;
            endcase
            e.upd = valid;
            e.tk  = tk;
        end
        if (valid) begin
            e.accept = tk;
            if (tk) e.redirect = tgt;
            e.misalign = tk & tgt[1];
            e.mispred  = e.misalign ? 1'b0 : (jr ? 1'b1 : (tk != pred));
        end
        return e;
    endfunction

    // Wait for the pending op's result, releasing the operand tags after 'stall' wait cycles.
    task automatic checkOutput(input string tag, input int stall);
        int   waits;
        int   lat;
        exp_t e;
        waits = 0;
        lat   = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (c == 1) begin
                #1;
                chk({tag, ".query_pre"}, {31'd0, query_taken}, {31'd0, bht_m[query_pc[5:2]][1]});
            end
            if (j_wait) waits++;
            if (j_valid) lat = c;
            if (c >= stall + 1) begin
                data1_depend = '0;
                data2_depend = '0;
            end
        end
        chk({tag, ".latency"}, lat, 2 + stall);
        chk({tag, ".wait_cycles"}, waits, stall);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (lat != 0) begin
                chk({tag, ".accept"},   {31'd0, j_accept},   {31'd0, e.accept});
                chk({tag, ".mispred"},  {31'd0, mispredict}, {31'd0, e.mispred});
                chk({tag, ".misalign"}, {31'd0, misalign},   {31'd0, e.misalign});
                chk({tag, ".link_we"},  {31'd0, link_we},    {31'd0, e.link_we});
                chk({tag, ".redirect"}, redirect_addr, e.redirect);
                chk({tag, ".link"},     link_data, e.link);
                if (e.upd) bht_m[e.idx] = sat(bht_m[e.idx], e.tk);
                last_e = e;
            end
        end
        @(negedge clk);
        chk({tag, ".pulse_end"}, {31'd0, j_valid}, 32'd0);
        #1;
        chk({tag, ".query_post"}, {31'd0, query_taken}, {31'd0, bht_m[query_pc[5:2]][1]});
    endtask

    // Issue one op, record its expected result and check it.
    task automatic applyStimulus(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] imm, input logic pred,
                                 input logic [31:0] a, input logic [31:0] b, input int stall);
        @(negedge clk);
        in_valid      = 1'b1;
        instr         = ins;
        pc_addr       = pc;
        imm_ex        = imm;
        pred_taken_in = pred;
        rs1_data      = a;
        rs2_data      = b;
        data1_depend  = (stall > 0) ? 2'd2 : 2'd0;
        data2_depend  = (stall > 0) ? 2'd1 : 2'd0;
        query_pc      = pc;
        #1;
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        sb.push_back(model(ins, pc, imm, pred, a, b));
        checkOutput(tag, stall);
    endtask

    task automatic scan_bht(input string tag);
        for (int i = 0; i < ENT; i++) begin
            @(negedge clk);
            query_pc = 32'h0000_5000 | (i << 2) | 32'd3;
            #1;
            chk($sformatf("%s.bht%0d", tag, i), {31'd0, query_taken}, {31'd0, bht_m[i][1]});
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".j_valid"},  {31'd0, j_valid},    32'd0);
        chk({tag, ".j_accept"}, {31'd0, j_accept},   32'd0);
        chk({tag, ".mispred"},  {31'd0, mispredict}, 32'd0);
        chk({tag, ".misalign"}, {31'd0, misalign},   32'd0);
        chk({tag, ".link_we"},  {31'd0, link_we},    32'd0);
        chk({tag, ".j_wait"},   {31'd0, j_wait},     32'd0);
        chk({tag, ".redirect"}, redirect_addr, 32'd0);
        chk({tag, ".link"},     link_data, 32'd0);
        chk({tag, ".in_ready"}, {31'd0, in_ready},   32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int seen;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; imm_ex = '0; pc_addr = '0;
        pred_taken_in = 1'b0; rs1_data = '0; rs2_data = '0; data1_depend = '0;
        data2_depend = '0; query_pc = '0;
        for (int i = 0; i < ENT; i++) bht_m[i] = 2'b01;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_zero("reset");
        scan_bht("reset");

        applyStimulus("beq",    mk(7'h63, 3'd0), 32'h100, 32'h20, 1'b0, 32'd5, 32'd5, 0);
        applyStimulus("bgeu",   mk(7'h63, 3'd7), 32'h104, 32'h40, 1'b1, 32'hFFFF_FFFF, 32'd1, 0);
        applyStimulus("bge",    mk(7'h63, 3'd5), 32'h108, 32'h40, 1'b1, 32'hFFFF_FFFF, 32'd1, 0);
        applyStimulus("jalr_w", mk(7'h67, 3'd0), 32'h200, 32'h0,  1'b0, 32'h203, 32'd0, 3);
        applyStimulus("jal",    mk(7'h6f, 3'd0), 32'h300, 32'h10, 1'b1, 32'd0, 32'd0, 0);
        applyStimulus("jalr",   mk(7'h67, 3'd0), 32'h400, 32'hFFFF_FFF8, 1'b1, 32'h1000, 32'd0, 0);
        applyStimulus("bne",    mk(7'h63, 3'd1), 32'h10C, 32'h40, 1'b1, 32'd3, 32'd3, 0);
        applyStimulus("blt",    mk(7'h63, 3'd4), 32'h110, 32'h22, 1'b1, 32'hFFFF_FFFB, 32'd3, 0);
        applyStimulus("bltu",   mk(7'h63, 3'd6), 32'h114, 32'h40, 1'b0, 32'hFFFF_FFFB, 32'd3, 2);
        applyStimulus("f3_2",   mk(7'h63, 3'd2), 32'h118, 32'h40, 1'b1, 32'd1, 32'd1, 0);
        applyStimulus("other",  mk(7'h33, 3'd0), 32'h11C, 32'h40, 1'b1, 32'd1, 32'd1, 0);
        scan_bht("mixed");

        for (int k = 0; k < 4; k++)
            applyStimulus($sformatf("sat_up%0d", k), mk(7'h63, 3'd0), 32'h13C, 32'h8, 1'b0, 32'd7, 32'd7, 0);
        for (int k = 0; k < 5; k++)
            applyStimulus($sformatf("sat_dn%0d", k), mk(7'h63, 3'd0), 32'h13C, 32'h8, 1'b0, 32'd7, 32'd9, 0);
        applyStimulus("sat_floor", mk(7'h63, 3'd0), 32'h13C, 32'h8, 1'b0, 32'd7, 32'd7, 0);
        scan_bht("sat");

        // Flush in the cycle the op would resolve.
        @(negedge clk);
        in_valid = 1'b1; instr = mk(7'h63, 3'd0); pc_addr = 32'h100; imm_ex = 32'h60;
        pred_taken_in = 1'b0; rs1_data = 32'd1; rs2_data = 32'd1;
        data1_depend = '0; data2_depend = '0;
        #1;
        chk("flush.in_ready_issue", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("flush.in_ready_during", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush.j_valid", {31'd0, j_valid}, 32'd0);
        chk("flush.in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("flush.held_redirect", redirect_addr, last_e.redirect);
        chk("flush.held_accept", {31'd0, j_accept}, {31'd0, last_e.accept});
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (j_valid) seen++;
        end
        chk("flush.no_result", seen, 0);
        scan_bht("flush");

        // Reset while an op waits on its operands.
        @(negedge clk);
        in_valid = 1'b1; instr = mk(7'h67, 3'd0); pc_addr = 32'h500; imm_ex = 32'h4;
        pred_taken_in = 1'b0; rs1_data = 32'h800;
        data1_depend = 2'd2; data2_depend = 2'd0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_eval.j_wait_before", {31'd0, j_wait}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        data1_depend = '0;
        for (int i = 0; i < ENT; i++) bht_m[i] = 2'b01;
        #1;
        check_zero("rst_eval");
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (j_valid) seen++;
        end
        chk("rst_eval.dropped", seen, 0);
        scan_bht("rst_eval");

        applyStimulus("post_rst", mk(7'h63, 3'd0), 32'h100, 32'h20, 1'b1, 32'd2, 32'd2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
